alu181_seq: RTL
===============

Name: alu181_seq

Overview:
- Parametrised, clocked successor to the 4-bit 74181-style ALU slice.
- WIDTH is a multiple of 4 bits. The block is organised as SLICES = WIDTH/4 internal slices with ripple carry between them.
- Operands are registered, flags are registered, and a valid/ready handshake is used on both sides.
- A STAGED mode evaluates one 4-bit slice per clock, mimicking a physical carry chain of slices. The model machine datapath uses it as its main ALU.

Parameters:
- WIDTH, 8, operand/result width; must be a multiple of 4, minimum 4.
- STAGED, 1. Value 1: one slice per cycle, latency SLICES. Value 0: all slices in one cycle, latency 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- s  input  4  function select S3..S0.
- m  input  1  1 = logic, 0 = arithmetic.
- cin  input  1  carry in, active-high (+1).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- f  output  WIDTH  result.
- cout  output  1  carry out of the MSB, active-high.
- ovf  output  1  signed overflow.
- zero  output  1  f == 0.
- aeqb  output  1  f all ones (74181 A=B semantics).

Behaviour:
- Reset (async, any state): state IDLE; f=0; cout=ovf=zero=aeqb=0; out_valid=0; slice index=0; latched operands cleared. in_ready=0 while rst is high.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - IDLE: when in_valid, latch a, b, s, m, cin; go to BUSY; slice index=0; running carry=cin.
  - BUSY with STAGED=1: each edge computes slice k (bits 4k+3..4k) from the running carry, writes those f bits, updates the carry, and increments k. After slice SLICES-1, go to DONE.
  - BUSY with STAGED=0: one edge computes the full word, then DONE.
  - DONE: out_valid=1. f and flags stay stable until out_ready is sampled high; then go to IDLE with out_valid=0.
- Latency: accept at edge t. out_valid rises after edge t+SLICES (STAGED=1) or t+1 (STAGED=0).
- No new request is accepted while in BUSY or DONE. in_valid in those states is ignored; the requester must hold it.
- Inputs a, b, s, m, cin are sampled only at the accept edge. Later changes have no effect on the operation in progress.
- Logic mode (m=1): cout=0 and ovf=0. Functions by s:
  - 0 ~A; 1 ~(A|B); 2 ~A&B; 3 0
  - 4 ~(A&B); 5 ~B; 6 A^B; 7 A&~B
  - 8 ~A|B; 9 ~(A^B); A B; B A&B
  - C all-ones; D A|~B; E A|B; F A
- Arithmetic mode (m=0): f = P + Q + cin, taken modulo 2^WIDTH. (P,Q) by s:
  - 0 (A,0); 1 (A|B,0); 2 (A|~B,0); 3 (0,ones)
  - 4 (A,A&~B); 5 (A|B,A&~B); 6 (A,~B); 7 (A&~B,ones)
  - 8 (A,A&B); 9 (A,B); A (A|~B,A&B); B (A&B,ones)
  - C (A,A); D (A|B,A); E (A|~B,A); F (A,ones)
- Arithmetic flags:
  - cout = bit WIDTH of the (WIDTH+1)-bit sum P+Q+cin.
  - ovf = (P[MSB]==Q[MSB]) && (f[MSB]!=P[MSB]).
- STAGED=1 and STAGED=0 give bit-identical f, cout and ovf.
- zero and aeqb are computed from the final f in both modes. They are registered on the transition into DONE.
- In STAGED=1, partial f bits may be observed during BUSY. They are only valid when out_valid=1.
- Reset mid-operation discards the operation; no out_valid is produced for it.

Test Plan:
- WIDTH=8, STAGED=1: a=65, b=A7, m=0, s=9, cin=0 -> f=0C, cout=1, ovf=0, zero=0. out_valid high exactly 2 edges after accept.
- Same operands with cin=1 -> f=0D. Then s=6, cin=1 -> f=BE, cout=0, ovf=1.
- Logic mode: m=1, s=6 -> f=C2. Then s=9 -> f=3D, cout=0, ovf=0.
- a=b=3C, m=0, s=6, cin=0 -> f=FF, aeqb=1, cout=0. Then m=1, s=3 -> f=00, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: f and flags stable, in_ready=0.
  - A second in_valid is not accepted until the cycle after out_ready=1.
- Reset and parameter sweep:
  - Assert rst mid-BUSY (WIDTH=16, STAGED=1) -> immediate IDLE, all outputs 0, no out_valid.
  - Repeat all vectors with WIDTH=16 and STAGED=0/1 -> identical results, latency 1 vs 4.

Source files
------------

// File: rtl/alu181_seq.sv
// Clocked, parametrised 74181-style ALU built from 4-bit slices with ripple carry.
// STAGED=1 evaluates one slice per clock (latency SLICES), STAGED=0 the whole word in one clock.
module alu181_seq #(
  parameter int WIDTH  = 8,
  parameter int STAGED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             aeqb
);

  localparam int SLICES = WIDTH / 4;
  localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, f_q;
  logic [3:0]       s_q;
  logic             m_q, carry_q;
  logic [KW-1:0]    k_q;
  logic             cout_q, ovf_q, zero_q, aeqb_q, out_valid_q;

  logic [6:0]       stg_r, full_r, last_r;
  logic [WIDTH-1:0] f_stg, f_full, f_d;
  logic             chain_c, last, cout_d, ovf_d, zero_d, aeqb_d;

  // Result packing: {carry out, P msb, Q msb, f[3:0]}. Logic mode forces carry and P/Q msbs to 0.
  function automatic logic [6:0] slice_op(input logic [3:0] x, input logic [3:0] y,
                                          input logic [3:0] sel, input logic lmode,
                                          input logic ci);
    logic [3:0] p, q, lf;
    logic [4:0] sum;
    p  = x;
    q  = 4'h0;
    lf = x;
    case (sel)
      4'h0: begin p = x;       q = 4'h0;    lf = ~x;       end
      4'h1: begin p = x | y;   q = 4'h0;    lf = ~(x | y); end
      4'h2: begin p = x | ~y;  q = 4'h0;    lf = ~x & y;   end
      4'h3: begin p = 4'h0;    q = 4'hF;    lf = 4'h0;     end
      4'h4: begin p = x;       q = x & ~y;  lf = ~(x & y); end
      4'h5: begin p = x | y;   q = x & ~y;  lf = ~y;       end
      4'h6: begin p = x;       q = ~y;      lf = x ^ y;    end
      4'h7: begin p = x & ~y;  q = 4'hF;    lf = x & ~y;   end
      4'h8: begin p = x;       q = x & y;   lf = ~x | y;   end
      4'h9: begin p = x;       q = y;       lf = ~(x ^ y); end
      4'hA: begin p = x | ~y;  q = x & y;   lf = y;        end
      4'hB: begin p = x & y;   q = 4'hF;    lf = x & y;    end
      4'hC: begin p = x;       q = x;       lf = 4'hF;     end
      4'hD: begin p = x | y;   q = x;       lf = x | ~y;   end
      4'hE: begin p = x | ~y;  q = x;       lf = x | y;    end
      default: begin p = x;    q = 4'hF;    lf = x;        end
    endcase
    sum = {1'b0, p} + {1'b0, q} + {4'b0, ci};
    return lmode ? {3'b000, lf} : {sum[4], p[3], q[3], sum[3:0]};
  endfunction

  always_comb begin
    stg_r   = '0;
    f_stg   = f_q;
    for (int i = 0; i < SLICES; i++) begin
      if (k_q == KW'(i)) begin
        stg_r            = slice_op(a_q[4*i +: 4], b_q[4*i +: 4], s_q, m_q, carry_q);
        f_stg[4*i +: 4]  = stg_r[3:0];
      end
    end

    full_r  = '0;
    f_full  = '0;
    chain_c = carry_q;
    for (int i = 0; i < SLICES; i++) begin
      full_r            = slice_op(a_q[4*i +: 4], b_q[4*i +: 4], s_q, m_q, chain_c);
      f_full[4*i +: 4]  = full_r[3:0];
      chain_c           = full_r[6];
    end

    if (STAGED != 0) begin
      f_d    = f_stg;
      last_r = stg_r;
      last   = (k_q == KW'(SLICES - 1));
    end else begin
      f_d    = f_full;
      last_r = full_r;
      last   = 1'b1;
    end

    // last_r holds the MSB slice whenever last is set, so its P/Q msbs give the sign inputs.
    cout_d = last_r[6];
    ovf_d  = !m_q && (last_r[5] == last_r[4]) && (f_d[WIDTH-1] != last_r[5]);
    zero_d = (f_d == '0);
    aeqb_d = &f_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      m_q         <= 1'b0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      f_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      aeqb_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= s;
            m_q     <= m;
            carry_q <= cin;
            k_q     <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          f_q     <= f_d;
          carry_q <= last_r[6];
          k_q     <= k_q + KW'(1);
          if (last) begin
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            aeqb_q      <= aeqb_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign aeqb      = aeqb_q;

endmodule
